alu_seq_ctrl: RTL and testbench

Command sequencer that owns a 4-entry operand register file and drives the 8-bit registered ALU datapath (`select`/`R2`/`R3` in, registered `R0`/`R0_carry` out). It accepts one ALU command at a time over a valid/ready handshake. For each command it:
- reads two source registers and presents them, with the opcode, to the ALU;
- waits out the ALU's register latency;
- writes the result back to a destination register and reports it on a one-cycle done strobe.

It sits between the command source (testbench or future fetch unit) and the ALU top level.

---
 rtl/alu_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: serial command sequencer that owns a 4-entry register file and drives a registered ALU.
// Optional sticky carry flag is built when ALU_SEQ_CARRY_FLAG_EN is defined.
module alu_seq_ctrl #(
   parameter int size    = 8,
   parameter int n       = 3,
   parameter int ALU_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [n-1:0]    cmd_op,
   input  logic [1:0]      cmd_srca,
   input  logic [1:0]      cmd_srcb,
   input  logic [1:0]      cmd_dst,
   input  logic            ld_en,
   input  logic [1:0]      ld_addr,
   input  logic [size-1:0] ld_data,
   output logic [size-1:0] alu_a,
   output logic [size-1:0] alu_b,
   output logic [n-1:0]    alu_select,
   input  logic [size-1:0] alu_result,
   input  logic            alu_carry,
   output logic            done_valid,
   output logic [size-1:0] done_data,
   output logic            done_carry,
   output logic            carry_flag
);

   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

   state_t          state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [n-1:0]    op_q;
   logic [1:0]      srca_q, srcb_q, dst_q;
   logic [size-1:0] rf [4];
   logic [size-1:0] hold_a, hold_b;
   logic [size-1:0] done_data_q;
   logic            done_carry_q;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      cmd_ready  = 1'b0;
      alu_a      = '0;
      alu_b      = '0;
      alu_select = '0;
      done_valid = 1'b0;
      done_data  = done_data_q;
      done_carry = done_carry_q;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = ISSUE;
         end
         ISSUE: begin
            alu_a      = rf[srca_q];
            alu_b      = rf[srcb_q];
            alu_select = op_q;
            if (ALU_LAT > 1) begin
               state_nxt = WAIT;
               cnt_nxt   = CNT_W'(ALU_LAT - 1);
            end else begin
               state_nxt = WB;
            end
         end
         WAIT: begin
            alu_a      = hold_a;
            alu_b      = hold_b;
            alu_select = op_q;
            cnt_nxt    = cnt - CNT_W'(1);
            if (cnt_nxt == '0) state_nxt = WB;
         end
         WB: begin
            alu_a      = hold_a;
            alu_b      = hold_b;
            alu_select = op_q;
            done_valid = 1'b1;
            done_data  = alu_result;
            done_carry = alu_carry;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control and architectural state; writeback follows the direct load so it wins on a shared index.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         done_data_q  <= '0;
         done_carry_q <= 1'b0;
         for (int i = 0; i < 4; i++) rf[i] <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (ld_en) rf[ld_addr] <= ld_data;
         if (state == WB) begin
            rf[dst_q]    <= alu_result;
            done_data_q  <= alu_result;
            done_carry_q <= alu_carry;
         end
      end
   end

   // Command latch and operand hold for the ALU latency window.
   always_ff @(posedge clk) begin
      if (cmd_valid && cmd_ready) begin
         op_q   <= cmd_op;
         srca_q <= cmd_srca;
         srcb_q <= cmd_srcb;
         dst_q  <= cmd_dst;
      end
      if (state == ISSUE) begin
         hold_a <= rf[srca_q];
         hold_b <= rf[srcb_q];
      end
   end

`ifdef ALU_SEQ_CARRY_FLAG_EN
   logic flag_q;

   always_ff @(posedge clk) begin
      if (rst)                flag_q <= 1'b0;
      else if (state == WB)   flag_q <= alu_carry;
   end

   assign carry_flag = flag_q;
`else
   assign carry_flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: one instance with ALU_LAT=1 and one with ALU_LAT=3, each behind a behavioural ALU.
module tb_alu_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
      case (s)
         3'b000:  return {1'b0, a};
         3'b010:  return {1'b0, a} + {1'b0, b};
         3'b011:  return {1'b0, a} - {1'b0, b};
         3'b100:  return {1'b0, a | b};
         3'b101:  return {1'b0, a & b};
         default: return {1'b0, a ^ b};
      endcase
   endfunction

   // ALU_LAT=1 instance
   logic       rst = 1'b1, cmd_valid = 1'b0, cmd_ready, ld_en = 1'b0;
   logic [2:0] cmd_op = '0, alu_select;
   logic [1:0] cmd_srca = '0, cmd_srcb = '0, cmd_dst = '0, ld_addr = '0;
   logic [7:0] ld_data = '0, alu_a, alu_b, alu_result, done_data;
   logic       alu_carry, done_valid, done_carry, carry_flag;

   alu_seq_ctrl #(.size(8), .n(3), .ALU_LAT(1)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_dst(cmd_dst), .ld_en(ld_en),
      .ld_addr(ld_addr), .ld_data(ld_data), .alu_a(alu_a), .alu_b(alu_b),
      .alu_select(alu_select), .alu_result(alu_result), .alu_carry(alu_carry),
      .done_valid(done_valid), .done_data(done_data), .done_carry(done_carry),
      .carry_flag(carry_flag)
   );

   always @(posedge clk) {alu_carry, alu_result} <= alu_f(alu_select, alu_a, alu_b);

   // ALU_LAT=3 instance
   logic       x_rst = 1'b1, x_cmd_valid = 1'b0, x_cmd_ready, x_ld_en = 1'b0;
   logic [2:0] x_cmd_op = '0, x_alu_select;
   logic [1:0] x_cmd_srca = '0, x_cmd_srcb = '0, x_cmd_dst = '0, x_ld_addr = '0;
   logic [7:0] x_ld_data = '0, x_alu_a, x_alu_b, x_alu_result, x_done_data;
   logic       x_alu_carry, x_done_valid, x_done_carry, x_carry_flag;
   logic [8:0] xp [3];

   alu_seq_ctrl #(.size(8), .n(3), .ALU_LAT(3)) u_dut3 (
      .clk(clk), .rst(x_rst), .cmd_valid(x_cmd_valid), .cmd_ready(x_cmd_ready), .cmd_op(x_cmd_op),
      .cmd_srca(x_cmd_srca), .cmd_srcb(x_cmd_srcb), .cmd_dst(x_cmd_dst), .ld_en(x_ld_en),
      .ld_addr(x_ld_addr), .ld_data(x_ld_data), .alu_a(x_alu_a), .alu_b(x_alu_b),
      .alu_select(x_alu_select), .alu_result(x_alu_result), .alu_carry(x_alu_carry),
      .done_valid(x_done_valid), .done_data(x_done_data), .done_carry(x_done_carry),
      .carry_flag(x_carry_flag)
   );

   always @(posedge clk) begin
      xp[0] <= alu_f(x_alu_select, x_alu_a, x_alu_b);
      xp[1] <= xp[0];
      xp[2] <= xp[1];
   end
   assign {x_alu_carry, x_alu_result} = xp[2];

   // Reference register file, carry flag and scoreboard
   typedef struct {
      logic [8:0] res;
      int         acc;
   } exp_t;

   exp_t       sbq[$];
   exp_t       mon_e;
   logic [7:0] mrf [4] = '{default: 8'h00};
   logic       mflag = 1'b0;
   int         dones = 0;
   int         x_dones = 0;

   function automatic logic exp_flag();
`ifdef ALU_SEQ_CARRY_FLAG_EN
      return mflag;
`else
      return 1'b0;
`endif
   endfunction

   always @(negedge clk) begin
      if (done_valid) begin
         dones++;
         if (sbq.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            check("done_data", 32'(done_data), 32'(mon_e.res[7:0]));
            check("done_carry", 32'(done_carry), 32'(mon_e.res[8]));
            check("latency", 32'(cyc - mon_e.acc), 32'd2);
         end
      end
      if (x_done_valid) x_dones++;
   end

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
      mrf[a] = d;
   endtask

   // Presents a command, waits for its accept, checks the ISSUE cycle and returns there.
   task automatic do_cmd(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] d, input bit hold, output int acc);
      logic [8:0] r;
      int         i;
      cmd_op = op; cmd_srca = a; cmd_srcb = b; cmd_dst = d; cmd_valid = 1'b1;
      i = 0;
      while (!cmd_ready && i < 20) begin
         @(negedge clk);
         i++;
      end
      check("ready_wait", 32'(cmd_ready), 32'd1);
      acc = cyc;
      r = alu_f(op, mrf[a], mrf[b]);
      sbq.push_back('{res: r, acc: cyc});
      @(negedge clk);
      check("issue_a", 32'(alu_a), 32'(mrf[a]));
      check("issue_b", 32'(alu_b), 32'(mrf[b]));
      check("issue_sel", 32'(alu_select), 32'(op));
      mrf[d] = r[7:0];
      mflag  = r[8];
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (!cmd_ready && i < 20) begin
         @(negedge clk);
         i++;
      end
      check("idle_wait", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc1, acc2, d0, i;

      repeat (2) @(negedge clk);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_alu", 32'({alu_a, alu_b, alu_select}), 32'd0);
      check("rst_done", 32'({done_valid, done_data, done_carry}), 32'd0);
      check("rst_flag", 32'(carry_flag), 32'd0);
      rst = 1'b0; x_rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(cmd_ready), 32'd1);

      // add 5+3 into r2
      load(2'd0, 8'h05); load(2'd1, 8'h03);
      do_cmd(3'b010, 2'd0, 2'd1, 2'd2, 1'b0, acc1);
      wait_idle();

      // add FF+01 into r3 with carry, flag retained across a load, then r3-r3
      load(2'd0, 8'hFF); load(2'd1, 8'h01);
      do_cmd(3'b010, 2'd0, 2'd1, 2'd3, 1'b0, acc1);
      wait_idle();
      check("flag_set", 32'(carry_flag), 32'(exp_flag()));
      load(2'd0, 8'h11);
      check("flag_keep", 32'(carry_flag), 32'(exp_flag()));
      do_cmd(3'b011, 2'd3, 2'd3, 2'd3, 1'b0, acc1);
      wait_idle();
      check("flag_clr", 32'(carry_flag), 32'(exp_flag()));
      check("done_hold", 32'({done_data, done_carry}), 32'd0);

      // back-to-back with a dependency on the first destination
      load(2'd0, 8'h02); load(2'd1, 8'h03);
      d0 = dones;
      do_cmd(3'b010, 2'd0, 2'd1, 2'd2, 1'b1, acc1);
      do_cmd(3'b010, 2'd2, 2'd1, 2'd3, 1'b0, acc2);
      check("accept_gap", 32'(acc2 - acc1), 32'd3);
      wait_idle();
      @(negedge clk);
      check("b2b_dones", 32'(dones - d0), 32'd2);

      // direct load colliding with writeback, then to a different index
      load(2'd0, 8'h05); load(2'd1, 8'h03);
      do_cmd(3'b010, 2'd0, 2'd1, 2'd2, 1'b0, acc1);
      @(negedge clk);
      check("wb_phase", 32'(done_valid), 32'd1);
      ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'hAA;
      @(negedge clk);
      ld_en = 1'b0;
      do_cmd(3'b010, 2'd0, 2'd1, 2'd2, 1'b0, acc1);
      @(negedge clk);
      check("wb_phase2", 32'(done_valid), 32'd1);
      ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'hAA;
      @(negedge clk);
      ld_en = 1'b0;
      mrf[1] = 8'hAA;
      do_cmd(3'b000, 2'd1, 2'd2, 2'd0, 1'b0, acc1);
      wait_idle();

      // or / and
      load(2'd0, 8'hF0); load(2'd1, 8'h3C);
      do_cmd(3'b100, 2'd0, 2'd1, 2'd2, 1'b0, acc1);
      wait_idle();
      do_cmd(3'b101, 2'd0, 2'd1, 2'd3, 1'b0, acc1);
      wait_idle();
      @(negedge clk);
      check("sb_drained", 32'(sbq.size()), 32'd0);

      // ALU_LAT=3 instance: reset during WAIT aborts the command
      x_ld_en = 1'b1; x_ld_addr = 2'd0; x_ld_data = 8'h05;
      @(negedge clk);
      x_ld_addr = 2'd1; x_ld_data = 8'h03;
      @(negedge clk);
      x_ld_en = 1'b0;
      x_cmd_op = 3'b010; x_cmd_srca = 2'd0; x_cmd_srcb = 2'd1; x_cmd_dst = 2'd2; x_cmd_valid = 1'b1;
      check("x_ready", 32'(x_cmd_ready), 32'd1);
      @(negedge clk);
      x_cmd_valid = 1'b0;
      check("x_issue_a", 32'(x_alu_a), 32'h05);
      @(negedge clk);
      check("x_wait_a", 32'(x_alu_a), 32'h05);
      x_rst = 1'b1;
      @(negedge clk);
      x_rst = 1'b0;
      check("x_rst_ready", 32'(x_cmd_ready), 32'd1);
      check("x_rst_alu", 32'({x_alu_a, x_alu_b, x_alu_select}), 32'd0);
      check("x_rst_done", 32'({x_done_valid, x_done_data, x_done_carry}), 32'd0);
      check("x_rst_flag", 32'(x_carry_flag), 32'd0);
      repeat (6) @(negedge clk);
      check("x_no_done", 32'(x_dones), 32'd0);

      // r2 (aborted destination) and r1 read back as zero; LAT=3 latency
      x_cmd_op = 3'b000; x_cmd_srca = 2'd2; x_cmd_srcb = 2'd1; x_cmd_dst = 2'd0; x_cmd_valid = 1'b1;
      acc1 = cyc;
      @(negedge clk);
      x_cmd_valid = 1'b0;
      check("x_dst_zero", 32'(x_alu_a), 32'd0);
      check("x_r1_zero", 32'(x_alu_b), 32'd0);
      i = 0;
      while (!x_done_valid && i < 10) begin
         @(negedge clk);
         i++;
      end
      check("x_done_seen", 32'(x_done_valid), 32'd1);
      check("x_latency", 32'(cyc - acc1), 32'd4);
      check("x_done_data", 32'(x_done_data), 32'd0);
      repeat (3) @(negedge clk);
      check("x_done_count", 32'(x_dones), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
